// File: rtl/pint_irq_pkg.sv
// Shared types and defaults for the pin-change interrupt arbiter.
package pint_irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0010;
  localparam int unsigned VEC_STRIDE_DEF = 4;

  // Bits needed to hold an index in 0..n-1; never less than 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pint_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
module pint_prio_enc
  import pint_irq_pkg::*;
#(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = clog2(N)
) (
  input  logic [N-1:0]     req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // Scan from the top down so the lowest asserted index is written last.
  always_comb begin
    idx_o   = '0;
    valid_o = |req_i;
    for (int unsigned i = N; i > 0; i--) begin
      if (req_i[i-1]) begin
        idx_o = IDX_W'(i - 1);
      end
    end
  end

endmodule

// File: rtl/pint_irq_arbiter.sv
// Interrupt arbiter: sticky pending capture, masking, fixed priority and
// request/ack/return handshake with the core trap logic.
module pint_irq_arbiter
  import pint_irq_pkg::*;
#(
  parameter int unsigned      N_SRC      = 3,
  parameter int unsigned      VEC_W      = 32,
  parameter logic [VEC_W-1:0] VEC_BASE   = VEC_W'(VEC_BASE_DEF),
  parameter int unsigned      VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_in,
  input  logic [N_SRC-1:0] irq_en,
  input  logic             global_ie,
  input  logic [N_SRC-1:0] clr_pend,
  input  logic             irq_ack,
  input  logic             irq_ret,
  output logic             irq_req,
  output logic [VEC_W-1:0] irq_vector,
  output logic [N_SRC-1:0] irq_grant,
  output logic [N_SRC-1:0] pending,
  output logic             in_service
);

  localparam int unsigned IDX_W = clog2(N_SRC);

  state_t           state_q, state_d;
  logic [N_SRC-1:0] irq_in_q;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] grant_q, grant_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic             req_q, req_d;
  logic             insvc_q, insvc_d;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] ack_clr;
  logic [N_SRC-1:0] enc_onehot;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_valid;
  logic             withdraw;
  logic [VEC_W-1:0] vec_calc;

  assign rise       = irq_in & ~irq_in_q;
  assign eligible   = pending_q & irq_en & {N_SRC{global_ie}};
  assign withdraw   = ~|(eligible & grant_q);
  assign enc_onehot = N_SRC'(1) << enc_idx;
  assign vec_calc   = VEC_BASE + VEC_W'(VEC_W'(enc_idx) * VEC_W'(VEC_STRIDE));

  pint_prio_enc #(
    .N     (N_SRC),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .req_i   (eligible),
    .idx_o   (enc_idx),
    .valid_o (enc_valid)
  );

  // Pending update: clears applied first, then new edges OR'd in so a
  // same-cycle set survives a clear of the same bit.
  always_comb begin
    pending_d = (pending_q & ~(clr_pend | ack_clr)) | rise;
  end

  // Handshake FSM next-state and registered-output values.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    vec_d   = vec_q;
    grant_d = grant_q;
    insvc_d = insvc_q;
    ack_clr = '0;
    unique case (state_q)
      ST_IDLE: begin
        req_d   = 1'b0;
        insvc_d = 1'b0;
        grant_d = '0;
        vec_d   = '0;
        if (enc_valid) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          grant_d = enc_onehot;
          vec_d   = vec_calc;
        end
      end
      ST_REQ: begin
        // Ack takes precedence over a coincident withdrawal.
        if (irq_ack) begin
          state_d = ST_SERVICE;
          req_d   = 1'b0;
          insvc_d = 1'b1;
          ack_clr = grant_q;
        end else if (withdraw) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
          grant_d = '0;
          vec_d   = '0;
        end
      end
      ST_SERVICE: begin
        if (irq_ret) begin
          state_d = ST_IDLE;
          insvc_d = 1'b0;
          grant_d = '0;
          vec_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        insvc_d = 1'b0;
        grant_d = '0;
        vec_d   = '0;
      end
    endcase
  end

  // State, history and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      irq_in_q  <= '0;
      pending_q <= '0;
      grant_q   <= '0;
      vec_q     <= '0;
      req_q     <= 1'b0;
      insvc_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      irq_in_q  <= irq_in;
      pending_q <= pending_d;
      grant_q   <= grant_d;
      vec_q     <= vec_d;
      req_q     <= req_d;
      insvc_q   <= insvc_d;
    end
  end

  assign irq_req    = req_q;
  assign irq_vector = vec_q;
  assign irq_grant  = grant_q;
  assign pending    = pending_q;
  assign in_service = insvc_q;

endmodule

// File: tb/tb_pint_irq_arbiter.sv
// Directed self-checking bench for pint_irq_arbiter.
module tb_pint_irq_arbiter;

  logic        clk;
  logic        reset;
  logic [2:0]  irq_in;
  logic [2:0]  irq_en;
  logic        global_ie;
  logic [2:0]  clr_pend;
  logic        irq_ack;
  logic        irq_ret;
  logic        irq_req;
  logic [31:0] irq_vector;
  logic [2:0]  irq_grant;
  logic [2:0]  pending;
  logic        in_service;

  int checks;
  int errors;

  pint_irq_arbiter #(
    .N_SRC      (3),
    .VEC_W      (32),
    .VEC_BASE   (32'h0000_0010),
    .VEC_STRIDE (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .irq_en     (irq_en),
    .global_ie  (global_ie),
    .clr_pend   (clr_pend),
    .irq_ack    (irq_ack),
    .irq_ret    (irq_ret),
    .irq_req    (irq_req),
    .irq_vector (irq_vector),
    .irq_grant  (irq_grant),
    .pending    (pending),
    .in_service (in_service)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    irq_in    = '0;
    irq_en    = '0;
    global_ie = 1'b0;
    clr_pend  = '0;
    irq_ack   = 1'b0;
    irq_ret   = 1'b0;
    tick();
    tick();
    check("rst_req",     32'(irq_req),    32'd0);
    check("rst_vec",     irq_vector,      32'd0);
    check("rst_grant",   32'(irq_grant),  32'd0);
    check("rst_pend",    32'(pending),    32'd0);
    check("rst_insvc",   32'(in_service), 32'd0);
    reset = 1'b0;
    tick();
    check("post_rst_req", 32'(irq_req), 32'd0);

    // Single source on bit 1
    irq_en    = 3'b111;
    global_ie = 1'b1;
    irq_in    = 3'b010;
    tick();
    irq_in = 3'b000;
    check("s1_pend_t1", 32'(pending), 32'h2);
    check("s1_req_t1",  32'(irq_req), 32'd0);
    tick();
    check("s1_req_t2",   32'(irq_req),   32'd1);
    check("s1_vec_t2",   irq_vector,     32'h14);
    check("s1_grant_t2", 32'(irq_grant), 32'h2);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check("s1_ack_pend",  32'(pending),    32'h0);
    check("s1_ack_insvc", 32'(in_service), 32'd1);
    check("s1_ack_req",   32'(irq_req),    32'd0);
    irq_ret = 1'b1;
    tick();
    irq_ret = 1'b0;
    check("s1_ret_insvc", 32'(in_service), 32'd0);
    check("s1_ret_grant", 32'(irq_grant),  32'h0);

    // Priority freeze: bit 2 first, then bit 0 while in REQ
    irq_in = 3'b100;
    tick();
    check("pf_pend_a", 32'(pending), 32'h4);
    irq_in = 3'b101;
    tick();
    check("pf_req",    32'(irq_req), 32'd1);
    check("pf_vec_a",  irq_vector,   32'h18);
    check("pf_pend_b", 32'(pending), 32'h5);
    irq_in = 3'b000;
    tick();
    check("pf_vec_frozen",   irq_vector,     32'h18);
    check("pf_grant_frozen", 32'(irq_grant), 32'h4);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check("pf_ack_pend", 32'(pending), 32'h1);
    irq_ret = 1'b1;
    tick();
    irq_ret = 1'b0;
    check("pf_ret1_req", 32'(irq_req), 32'd0);
    tick();
    check("pf_ret2_req", 32'(irq_req), 32'd1);
    check("pf_ret2_vec", irq_vector,   32'h10);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    irq_ret = 1'b1;
    tick();
    irq_ret = 1'b0;
    check("pf_end_pend", 32'(pending), 32'h0);

    // Masking
    irq_en = 3'b000;
    irq_in = 3'b001;
    tick();
    irq_in = 3'b000;
    check("mk_pend", 32'(pending), 32'h1);
    tick();
    tick();
    check("mk_req_masked", 32'(irq_req), 32'd0);
    irq_en = 3'b001;
    tick();
    check("mk_req_en",  32'(irq_req), 32'd1);
    check("mk_vec_en",  irq_vector,   32'h10);
    global_ie = 1'b0;
    tick();
    check("mk_gie_req",   32'(irq_req),   32'd0);
    check("mk_gie_grant", 32'(irq_grant), 32'h0);
    global_ie = 1'b1;
    tick();
    check("mk_gie_back", 32'(irq_req), 32'd1);
    clr_pend = 3'b001;
    tick();
    clr_pend = 3'b000;
    check("mk_clr_pend", 32'(pending), 32'h0);
    tick();
    check("mk_clr_req", 32'(irq_req), 32'd0);

    // Collision: clear and edge in the same cycle
    irq_en = 3'b000;
    irq_in = 3'b010;
    tick();
    irq_in = 3'b000;
    tick();
    check("co_pend_pre", 32'(pending), 32'h2);
    irq_in   = 3'b010;
    clr_pend = 3'b010;
    tick();
    check("co_set_wins", 32'(pending), 32'h2);
    tick();
    clr_pend = 3'b000;
    check("co_level_noset", 32'(pending), 32'h0);
    irq_in = 3'b000;
    tick();

    // Collision: ack and software clear of the granted bit together
    irq_en = 3'b111;
    irq_in = 3'b100;
    tick();
    irq_in = 3'b000;
    tick();
    check("ac_req", 32'(irq_req), 32'd1);
    check("ac_vec", irq_vector,   32'h18);
    irq_ack  = 1'b1;
    clr_pend = 3'b100;
    tick();
    irq_ack  = 1'b0;
    clr_pend = 3'b000;
    check("ac_insvc", 32'(in_service), 32'd1);
    check("ac_req0",  32'(irq_req),    32'd0);
    check("ac_pend",  32'(pending),    32'h0);
    irq_ret = 1'b1;
    tick();
    irq_ret = 1'b0;

    // Held level sets pending once; stray ack in IDLE ignored
    irq_en = 3'b000;
    irq_in = 3'b001;
    tick();
    check("hl_pend", 32'(pending), 32'h1);
    clr_pend = 3'b001;
    irq_ack  = 1'b1;
    tick();
    clr_pend = 3'b000;
    irq_ack  = 1'b0;
    check("hl_idle_ack", 32'(in_service), 32'd0);
    for (int i = 0; i < 8; i++) tick();
    check("hl_once", 32'(pending), 32'h0);
    irq_in = 3'b000;
    tick();

    // Edge during SERVICE: no nesting
    irq_en = 3'b111;
    irq_in = 3'b010;
    tick();
    irq_in = 3'b000;
    tick();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check("sv_insvc", 32'(in_service), 32'd1);
    irq_in = 3'b001;
    tick();
    irq_in = 3'b000;
    check("sv_pend", 32'(pending), 32'h1);
    tick();
    tick();
    check("sv_no_nest", 32'(irq_req), 32'd0);
    irq_ret = 1'b1;
    tick();
    irq_ret = 1'b0;
    check("sv_ret1_req",   32'(irq_req),    32'd0);
    check("sv_ret1_insvc", 32'(in_service), 32'd0);
    tick();
    check("sv_ret2_req", 32'(irq_req), 32'd1);
    check("sv_ret2_vec", irq_vector,   32'h10);
    irq_ret = 1'b1;
    tick();
    irq_ret = 1'b0;
    check("sv_stray_ret", 32'(irq_req), 32'd1);

    // Reset asserted mid-REQ
    #2;
    reset = 1'b1;
    #1;
    check("mr_req",   32'(irq_req),    32'd0);
    check("mr_vec",   irq_vector,      32'd0);
    check("mr_grant", 32'(irq_grant),  32'h0);
    check("mr_pend",  32'(pending),    32'h0);
    check("mr_insvc", 32'(in_service), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("mr_idle_req",  32'(irq_req), 32'd0);
    check("mr_idle_pend", 32'(pending), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
